shift_add_mult8: RTL

SHIFT_ADD_MULT8 -- requirements
Module: shift_add_mult8

---
 rtl/shift_add_mult8_pkg.sv | 29 ++
 rtl/shift_add_mult8_if.sv | 32 +++
 rtl/shift_add_mult8_add_sub9.sv | 30 +++
 rtl/shift_add_mult8.sv | 86 ++++++++
 4 files changed

// File: rtl/shift_add_mult8_pkg.sv
// +--------------------------------------------------------------------+
// | mult_pkg : shared types and constants for shift_add_mult8           |
// | Revision : 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package mult_pkg;

  localparam int MULT_STEPS = 8;

  // ADDi states take even codes and SHFi states odd codes, so the step
  // sequence is a plain increment from CLR up to DONE.
  typedef enum logic [4:0] {
    IDLE = 5'd0,
    CLR  = 5'd1,
    ADD0 = 5'd2,  SHF0 = 5'd3,
    ADD1 = 5'd4,  SHF1 = 5'd5,
    ADD2 = 5'd6,  SHF2 = 5'd7,
    ADD3 = 5'd8,  SHF3 = 5'd9,
    ADD4 = 5'd10, SHF4 = 5'd11,
    ADD5 = 5'd12, SHF5 = 5'd13,
    ADD6 = 5'd14, SHF6 = 5'd15,
    ADD7 = 5'd16, SHF7 = 5'd17,
    DONE = 5'd18
  } mult_state_t;

endpackage

`default_nettype wire

// File: rtl/shift_add_mult8_if.sv
// +--------------------------------------------------------------------+
// | shift_add_mult8_if : control/data bundle of the shift-add multiplier |
// | Revision : 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

interface shift_add_mult8_if #(
  parameter int WIDTH = 8
);

  logic             run;
  logic             clear_a_load_b;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] aval;
  logic [WIDTH-1:0] bval;
  logic             xval;
  logic             busy;
  logic             done;

  modport master (
    output run, clear_a_load_b, din,
    input  aval, bval, xval, busy, done
  );

  modport slave (
    input  run, clear_a_load_b, din,
    output aval, bval, xval, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/shift_add_mult8_add_sub9.sv
// +--------------------------------------------------------------------+
// | add_sub9 : 9-bit ripple-carry adder/subtractor (s = a +/- b)         |
// | Revision : 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module add_sub9 (
  input  wire logic [8:0] a,
  input  wire logic [8:0] b,
  input  wire logic       sub,
  output logic      [8:0] s
);

  logic [8:0] w_bx;
  logic [8:0] w_c;

  assign w_bx   = b ^ {9{sub}};
  assign w_c[0] = sub;

  // The carry out of the top bit is dropped: the result wraps in 9 bits.
  for (genvar i = 0; i < 9; i++) begin : g_bit
    assign s[i] = a[i] ^ w_bx[i] ^ w_c[i];
    if (i < 8) begin : g_carry
      assign w_c[i+1] = (a[i] & w_bx[i]) | (a[i] & w_c[i]) | (w_bx[i] & w_c[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_add_mult8.sv
// +--------------------------------------------------------------------+
// | shift_add_mult8 : 8x8 signed sequential shift-add multiplier         |
// | Revision : 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

import mult_pkg::*;

module shift_add_mult8 #(
  parameter int WIDTH = 8
) (
  input  wire logic      clk,
  input  wire logic      rst,
  shift_add_mult8_if.slave bus
);

  mult_state_t      r_state;
  mult_state_t      w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_x;
  logic [WIDTH:0]   w_sum;
  logic             w_is_add;
  logic             w_is_shf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.run)  w_next_state = CLR;
      DONE:    if (!bus.run) w_next_state = IDLE;
      default: w_next_state = (r_state < DONE) ? mult_state_t'(r_state + 5'd1) : IDLE;
    endcase
  end

  assign w_is_add = (r_state >= ADD0) && (r_state < DONE) && !r_state[0];
  assign w_is_shf = (r_state >= SHF0) && (r_state < DONE) &&  r_state[0];

  // The final partial product carries negative weight, hence the subtract.
  add_sub9 u_add_sub9 (
    .a   ({r_a[WIDTH-1], r_a}),
    .b   ({bus.din[WIDTH-1], bus.din}),
    .sub (r_state == ADD7),
    .s   (w_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_x <= 1'b0;
    end else if (r_state == IDLE) begin
      if (bus.clear_a_load_b) begin
        r_b <= bus.din;
        r_a <= '0;
        r_x <= 1'b0;
      end
    end else if (r_state == CLR) begin
      r_a <= '0;
      r_x <= 1'b0;
    end else if (w_is_add) begin
      if (r_b[0]) begin
        {r_x, r_a} <= w_sum;
      end
    end else if (w_is_shf) begin
      r_a <= {r_x, r_a[WIDTH-1:1]};
      r_b <= {r_a[0], r_b[WIDTH-1:1]};
    end
  end

  assign bus.aval = r_a;
  assign bus.bval = r_b;
  assign bus.xval = r_x;
  assign bus.busy = (r_state != IDLE) && (r_state != DONE);
  assign bus.done = (r_state == DONE);

endmodule

`default_nettype wire
